jk_excitation_driver: RTL and testbench

JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

---
 rtl/jk_excitation_driver.sv | 138 +++++++++++++
 tb/tb_jk_excitation_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: converts a target Q word into per-stage J/K drive,
// pulses the stage bank enable once, waits SETTLE cycles, then verifies Q.
module jk_excitation_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             toggle_mode,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             en,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_target, w_target_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_j, w_j_nxt;
  logic [WIDTH-1:0] r_k, w_k_nxt;
  logic             r_en, w_en_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [7:0]       r_err_count, w_err_count_nxt;

  // Toggle encoding fires both inputs on changing bits; set/reset encoding drives only the needed side.
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t,
                                                input logic tog);
    excite_j = tog ? (q ^ t) : (~q & t);
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t,
                                                input logic tog);
    excite_k = tog ? (q ^ t) : (q & ~t);
  endfunction

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_target    <= {WIDTH{1'b0}};
      r_cnt       <= 4'd0;
      r_j         <= {WIDTH{1'b0}};
      r_k         <= {WIDTH{1'b0}};
      r_en        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_cnt       <= w_cnt_nxt;
      r_j         <= w_j_nxt;
      r_k         <= w_k_nxt;
      r_en        <= w_en_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_target_nxt    = r_target;
    w_cnt_nxt       = r_cnt;
    w_j_nxt         = {WIDTH{1'b0}};
    w_k_nxt         = {WIDTH{1'b0}};
    w_en_nxt        = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_count_nxt = r_err_count;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_target_nxt = in_data;
          w_j_nxt      = excite_j(q_in, in_data, toggle_mode);
          w_k_nxt      = excite_k(q_in, in_data, toggle_mode);
          w_en_nxt     = 1'b1;
          w_state_nxt  = DRIVE;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      DRIVE: begin
        w_cnt_nxt   = CNT_INIT;
        w_state_nxt = CHECK;
      end
      CHECK: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          if (q_in != r_target) begin
            w_err_nxt = 1'b1;
            // Counter sticks at all-ones rather than wrapping back to zero.
            if (r_err_count != 8'hFF) begin
              w_err_count_nxt = r_err_count + 8'd1;
            end else begin
              w_err_count_nxt = r_err_count;
            end
          end else begin
            w_err_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign J         = r_j;
  assign K         = r_k;
  assign en        = r_en;
  assign done      = r_done;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver (WIDTH=4, SETTLE=1) driving an
// ideal JK stage bank model with an optional stuck-at-0 fault mask.
module tb_jk_excitation_driver;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         toggle_mode;
  logic [W-1:0] q_in;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic         en;
  logic         done;
  logic         err;
  logic [7:0]   err_count;

  logic [W-1:0] q_bank = 4'b0000;
  logic [W-1:0] stuck_mask = 4'b0000;

  typedef struct { logic [W-1:0] j; logic [W-1:0] k; } jk_t;
  typedef struct { logic e; logic [7:0] cnt; } dn_t;
  jk_t exp_jk[$];
  dn_t exp_dn[$];
  jk_t cur_jk;
  dn_t cur_dn;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_en = -100;
  int gap_arm = 0;

  jk_excitation_driver #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .toggle_mode(toggle_mode), .q_in(q_in),
    .J(J), .K(K), .en(en), .done(done), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Ideal JK bank: Q+ = J&~Q | ~K&Q, with stuck bits forced low.
  assign q_in = q_bank & ~stuck_mask;
  always @(posedge clk) begin
    if (en) q_bank <= ((J & ~q_in) | (~K & q_in)) & ~stuck_mask;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT drives or completes a transfer.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (en) begin
        if (exp_jk.size() == 0) begin
          check("unexpected_en", 32'd1, 32'd0);
        end else begin
          cur_jk = exp_jk.pop_front();
          check("J", J, cur_jk.j);
          check("K", K, cur_jk.k);
        end
        if (gap_arm == 2) begin
          check("en_gap", cyc - last_en, 32'd3);
          gap_arm = 0;
        end else if (gap_arm == 1) begin
          gap_arm = 2;
        end
        last_en = cyc;
      end else begin
        check("JK_zero_without_en", {J, K}, 8'h00);
      end
      if (done) begin
        if (exp_dn.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur_dn = exp_dn.pop_front();
          check("err", err, cur_dn.e);
          check("err_count", err_count, cur_dn.cnt);
          check("ready_in_done", in_ready, 32'd1);
          check("done_latency", cyc - last_en, 32'd2);
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] ej, input logic [W-1:0] ek,
                      input bit has_done, input logic ee, input logic [7:0] ec);
    jk_t a;
    dn_t b;
    a.j = ej; a.k = ek;
    exp_jk.push_back(a);
    if (has_done) begin
      b.e = ee; b.cnt = ec;
      exp_dn.push_back(b);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic tm);
    int n;
    n = 0;
    @(negedge clk);
    in_data = d; toggle_mode = tm; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_jk.size() != 0 || exp_dn.size() != 0) && n < 30) begin
      @(negedge clk);
      #1 n++;
    end
    check("drain_timeout", exp_jk.size() + exp_dn.size(), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'b0000; toggle_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_J", J, 32'd0);
    check("rst_K", K, 32'd0);
    check("rst_en", en, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_err", err, 32'd0);
    check("rst_err_count", err_count, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_ready", in_ready, 32'd1);

    // Set/reset encoding from 0000 to 1010.
    push(4'b1010, 4'b0000, 1'b1, 1'b0, 8'd0);
    send(4'b1010, 1'b0);
    drain();
    check("q_after_1", q_in, 32'hA);

    // Toggle encoding 1010 -> 0110.
    push(4'b1100, 4'b1100, 1'b1, 1'b0, 8'd0);
    send(4'b0110, 1'b1);
    drain();
    check("q_after_2", q_in, 32'h6);

    // Target equal to current Q.
    push(4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0);
    send(4'b0110, 1'b0);
    drain();
    check("q_after_3", q_in, 32'h6);

    // Back-to-back with in_valid held high: 0110 -> 0001 -> 0011.
    push(4'b0001, 4'b0110, 1'b1, 1'b0, 8'd0);
    push(4'b0010, 4'b0000, 1'b1, 1'b0, 8'd0);
    gap_arm = 1;
    @(negedge clk);
    in_data = 4'b0001; toggle_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 4'b0011;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_accept_in_done", done, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    check("b2b_gap_seen", gap_arm, 32'd0);
    check("q_after_b2b", q_in, 32'h3);

    // Stuck-at-0 on bit0: every transfer to 0001 fails; counter saturates.
    stuck_mask = 4'b0001;
    push(4'b0001, 4'b0010, 1'b1, 1'b1, 8'd1);
    send(4'b0001, 1'b0);
    drain();
    for (int i = 2; i <= 256; i++) begin
      push(4'b0001, 4'b0000, 1'b1, 1'b1, (i > 255) ? 8'hFF : 8'(i));
      send(4'b0001, 1'b0);
      drain();
    end
    check("err_count_sat", err_count, 32'hFF);

    // Reset during CHECK abandons the transfer.
    stuck_mask = 4'b0000;
    push(4'b1111, 4'b0000, 1'b0, 1'b0, 8'd0);
    send(4'b1111, 1'b0);
    n = 0;
    while (!en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("en_before_rst", en, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_J", J, 32'd0);
    check("mid_rst_en", en, 32'd0);
    check("mid_rst_done", done, 32'd0);
    check("mid_rst_err", err, 32'd0);
    check("mid_rst_err_count", err_count, 32'd0);
    check("mid_rst_jk_consumed", exp_jk.size(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", in_ready, 32'd1);
    repeat (5) @(negedge clk);
    #1 check("post_rst_err_count", err_count, 32'd0);
    check("no_pending", exp_jk.size() + exp_dn.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
